// File: rtl/mini_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mini_cpu_pkg
// Description : State/opcode encodings and instruction field positions shared
//               by the mini CPU control unit and its ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package mini_cpu_pkg;

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_READ   = 3'd3,
        S_CALC   = 3'd4,
        S_WAIT   = 3'd5,
        S_STORE  = 3'd6,
        S_SHOW   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        OP_LOAD    = 3'd0,
        OP_ADD     = 3'd1,
        OP_ADDI    = 3'd2,
        OP_SUB     = 3'd3,
        OP_SUBI    = 3'd4,
        OP_MUL     = 3'd5,
        OP_CLEAR   = 3'd6,
        OP_DISPLAY = 3'd7
    } opcode_e;

    localparam int c_op_hi    = 15;
    localparam int c_op_lo    = 13;
    localparam int c_f0_hi    = 12;
    localparam int c_f0_lo    = 9;
    localparam int c_f1_hi    = 8;
    localparam int c_f1_lo    = 5;
    localparam int c_f2_hi    = 4;
    localparam int c_f2_lo    = 1;
    localparam int c_imm7_msb = 6;
    localparam int c_imm5_msb = 4;

    // Sign-extended immediate for the opcodes that carry one, zero otherwise.
    function automatic logic [15:0] decode_imm(input opcode_e op, input logic [15:0] ins);
        logic [15:0] imm;
        imm = '0;
        case (op)
            OP_LOAD:                  imm = {{(15-c_imm7_msb){ins[c_imm7_msb]}}, ins[c_imm7_msb:0]};
            OP_ADDI, OP_SUBI, OP_MUL: imm = {{(15-c_imm5_msb){ins[c_imm5_msb]}}, ins[c_imm5_msb:0]};
            default:                  imm = '0;
        endcase
        return imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mini_cpu_alu.sv
`default_nettype none
// ============================================================================
// Module      : mini_cpu_alu
// Description : Combinational 16-bit two's-complement datapath with signed
//               overflow detection.
// Revision    : 1.0 - initial release
// ============================================================================
module mini_cpu_alu
    import mini_cpu_pkg::*;
(
    input  opcode_e     opcode,
    input  logic [15:0] v1,
    input  logic [15:0] v2,
    input  logic [15:0] imm,
    output logic [15:0] result,
    output logic        ovf
);

    logic [15:0]        w_add_b;
    logic [15:0]        w_sub_b;
    logic [15:0]        w_sum;
    logic [15:0]        w_diff;
    logic signed [31:0] w_prod;

    assign w_add_b = (opcode == OP_ADDI) ? imm : v2;
    assign w_sub_b = (opcode == OP_SUBI) ? imm : v2;
    assign w_sum   = v1 + w_add_b;
    assign w_diff  = v1 - w_sub_b;
    assign w_prod  = $signed(v1) * $signed(imm);

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (opcode)
            OP_LOAD:          result = imm;
            OP_ADD, OP_ADDI: begin
                result = w_sum;
                ovf    = (v1[15] == w_add_b[15]) && (w_sum[15] != v1[15]);
            end
            OP_SUB, OP_SUBI: begin
                result = w_diff;
                ovf    = (v1[15] != w_sub_b[15]) && (w_diff[15] != v1[15]);
            end
            OP_MUL: begin
                result = w_prod[15:0];
                ovf    = (w_prod[31:16] != {16{w_prod[15]}});
            end
            OP_DISPLAY:       result = v1;
            default:          result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mini_cpu_control.sv
`default_nettype none
// ============================================================================
// Module      : mini_cpu_control
// Description : Instruction sequencer driving the memory bank handshake and
//               the display outputs. Define HANDSHAKE_TIMEOUT_EN to bound the
//               READ/STORE acknowledge waits by TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module mini_cpu_control
    import mini_cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        power,
    input  logic        exec,
    input  logic [15:0] instr,
    input  logic [15:0] v1RAM,
    input  logic [15:0] v2RAM,
    input  logic        read,
    input  logic        stored,
    output logic [2:0]  stateCPU,
    output logic [2:0]  opcode,
    output logic [3:0]  addr1,
    output logic [3:0]  addr2,
    output logic [3:0]  addr3,
    output logic [15:0] valorGuardarRAM,
    output logic [15:0] disp_value,
    output logic        disp_valid,
    output logic        ovf,
    output logic        err
);

    state_e      state_q, state_d;
    opcode_e     opcode_q, opcode_d;
    logic        exec_prev_q;
    logic [15:0] instr_q, instr_d;
    logic [3:0]  addr1_q, addr1_d, addr2_q, addr2_d, addr3_q, addr3_d;
    logic [15:0] imm_q, imm_d, v1_q, v1_d, v2_q, v2_d;
    logic [15:0] result_q, result_d, disp_q, disp_d;
    logic        ovf_q, ovf_d, disp_valid_q, disp_valid_d, err_q, err_d;
    logic [15:0] w_alu_result;
    logic        w_alu_ovf;
    logic        w_timeout;

    mini_cpu_alu u_alu (
        .opcode (opcode_q),
        .v1     (v1_q),
        .v2     (v2_q),
        .imm    (imm_q),
        .result (w_alu_result),
        .ovf    (w_alu_ovf)
    );

`ifdef HANDSHAKE_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_cnt_w-1:0] cnt_q, cnt_d;

    // Any state change restarts the count, so it is fresh on entry to READ/STORE.
    always_comb begin
        cnt_d = cnt_q + c_cnt_w'(1);
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign w_timeout = ((state_q == S_READ && !read) || (state_q == S_STORE && !stored))
                       && (cnt_q == c_cnt_w'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
    assign w_timeout    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        instr_d      = instr_q;
        addr1_d      = addr1_q;
        addr2_d      = addr2_q;
        addr3_d      = addr3_q;
        imm_d        = imm_q;
        v1_d         = v1_q;
        v2_d         = v2_q;
        result_d     = result_q;
        ovf_d        = ovf_q;
        disp_d       = disp_q;
        disp_valid_d = disp_valid_q;
        err_d        = err_q;
        case (state_q)
            S_OFF: if (power) state_d = S_FETCH;
            S_FETCH: begin
                if (exec && !exec_prev_q) begin
                    instr_d = instr;
                    state_d = S_DECODE;
                end else if (!power) begin
                    state_d = S_OFF;
                end
            end
            S_DECODE: begin
                opcode_d = opcode_e'(instr_q[c_op_hi:c_op_lo]);
                imm_d    = decode_imm(opcode_d, instr_q);
                addr1_d  = '0;
                addr2_d  = '0;
                addr3_d  = '0;
                err_d    = 1'b0;
                state_d  = S_READ;
                case (opcode_d)
                    OP_LOAD: begin
                        addr1_d = instr_q[c_f0_hi:c_f0_lo];
                        state_d = S_CALC;
                    end
                    OP_ADD, OP_SUB: begin
                        addr3_d = instr_q[c_f0_hi:c_f0_lo];
                        addr1_d = instr_q[c_f1_hi:c_f1_lo];
                        addr2_d = instr_q[c_f2_hi:c_f2_lo];
                    end
                    OP_ADDI, OP_SUBI, OP_MUL: begin
                        addr2_d = instr_q[c_f0_hi:c_f0_lo];
                        addr1_d = instr_q[c_f1_hi:c_f1_lo];
                    end
                    OP_DISPLAY: addr1_d = instr_q[c_f0_hi:c_f0_lo];
                    default:    state_d = S_WAIT;
                endcase
            end
            S_READ: begin
                if (read) begin
                    v1_d    = v1RAM;
                    v2_d    = v2RAM;
                    state_d = S_CALC;
                end else if (w_timeout) begin
                    err_d   = 1'b1;
                    state_d = S_SHOW;
                end
            end
            S_CALC: begin
                result_d = w_alu_result;
                ovf_d    = w_alu_ovf;
                state_d  = S_WAIT;
            end
            S_WAIT: state_d = S_STORE;
            S_STORE: begin
                if (stored) begin
                    state_d = S_SHOW;
                end else if (w_timeout) begin
                    err_d   = 1'b1;
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                // A timed-out instruction leaves the display untouched.
                if (!err_q) begin
                    disp_d       = (opcode_q == OP_CLEAR) ? 16'h0000 : result_q;
                    disp_valid_d = 1'b1;
                end
                state_d = S_FETCH;
            end
            default: state_d = S_OFF;
        endcase
        if (state_d == S_OFF) disp_valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_OFF;
            opcode_q     <= OP_LOAD;
            exec_prev_q  <= 1'b0;
            instr_q      <= '0;
            addr1_q      <= '0;
            addr2_q      <= '0;
            addr3_q      <= '0;
            imm_q        <= '0;
            v1_q         <= '0;
            v2_q         <= '0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
            disp_q       <= '0;
            disp_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            exec_prev_q  <= exec;
            instr_q      <= instr_d;
            addr1_q      <= addr1_d;
            addr2_q      <= addr2_d;
            addr3_q      <= addr3_d;
            imm_q        <= imm_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
            disp_q       <= disp_d;
            disp_valid_q <= disp_valid_d;
            err_q        <= err_d;
        end
    end

    assign stateCPU        = state_q;
    assign opcode          = opcode_q;
    assign addr1           = addr1_q;
    assign addr2           = addr2_q;
    assign addr3           = addr3_q;
    assign valorGuardarRAM = result_q;
    assign disp_value      = disp_q;
    assign disp_valid      = disp_valid_q;
    assign ovf             = ovf_q;
    assign err             = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mini_cpu_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_mini_cpu_control
// Description : Self-checking bench for mini_cpu_control with a reactive
//               memory model and an expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mini_cpu_control;

    logic        clk = 1'b0;
    logic        rst, power, exec, read, stored;
    logic [15:0] instr, v1RAM, v2RAM;
    logic [2:0]  stateCPU, opcode;
    logic [3:0]  addr1, addr2, addr3;
    logic [15:0] valorGuardarRAM, disp_value;
    logic        disp_valid, ovf, err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int rd_delay  = 1;
    int st_delay  = 2;
    bit no_ack    = 1'b0;
    int rd_cnt    = 0;
    int st_cnt    = 0;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] v1;
        logic [15:0] v2;
        int          rd_delay;
        bit          exec_in_store;
        bit          chk_val;
        logic [2:0]  e_op;
        logic [3:0]  e_a1;
        logic [3:0]  e_a2;
        logic [3:0]  e_a3;
        logic [15:0] e_val;
        logic        e_ovf;
        logic [15:0] e_disp;
        int          e_rd;
    } vec_t;

    vec_t vecs[10];
    vec_t sb[$];

    mini_cpu_control #(.TIMEOUT_CYCLES(15)) dut (
        .clk             (clk),
        .rst             (rst),
        .power           (power),
        .exec            (exec),
        .instr           (instr),
        .v1RAM           (v1RAM),
        .v2RAM           (v2RAM),
        .read            (read),
        .stored          (stored),
        .stateCPU        (stateCPU),
        .opcode          (opcode),
        .addr1           (addr1),
        .addr2           (addr2),
        .addr3           (addr3),
        .valorGuardarRAM (valorGuardarRAM),
        .disp_value      (disp_value),
        .disp_valid      (disp_valid),
        .ovf             (ovf),
        .err             (err)
    );

    always #5 clk = ~clk;

    // Memory: acknowledges after a configurable number of cycles in READ/STORE.
    always @(negedge clk) begin
        if (stateCPU == 3'd3) begin
            read   = !no_ack && (rd_cnt >= rd_delay);
            rd_cnt = rd_cnt + 1;
        end else begin
            read   = 1'b0;
            rd_cnt = 0;
        end
        if (stateCPU == 3'd6) begin
            stored = !no_ack && (st_cnt >= st_delay);
            st_cnt = st_cnt + 1;
        end else begin
            stored = 1'b0;
            st_cnt = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        vec_t e;
        int   rd_n;
        bit   pulsed;
        bit   done;
        rd_n   = 0;
        pulsed = 1'b0;
        done   = 1'b0;
        v1RAM    = v.v1;
        v2RAM    = v.v2;
        rd_delay = v.rd_delay;
        instr    = v.instr;
        exec     = 1'b1;
        sb.push_back(v);
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            exec = 1'b0;
            if (stateCPU == 3'd3) rd_n++;
            if (stateCPU == 3'd6 && v.exec_in_store && !pulsed) begin
                exec   = 1'b1;
                pulsed = 1'b1;
            end
            if (stateCPU == 3'd7) done = 1'b1;
        end
        e = sb.pop_front();
        if (!done) begin
            total_cnt++;
            $display("FAIL v%0d_show_reached: got state %0d expected 7 within 200 cycles", idx, stateCPU);
            return;
        end
        chk($sformatf("v%0d_opcode", idx), 32'(opcode), 32'(e.e_op));
        chk($sformatf("v%0d_addr1", idx), 32'(addr1), 32'(e.e_a1));
        chk($sformatf("v%0d_addr2", idx), 32'(addr2), 32'(e.e_a2));
        chk($sformatf("v%0d_addr3", idx), 32'(addr3), 32'(e.e_a3));
        chk($sformatf("v%0d_read_dwell", idx), 32'(rd_n), 32'(e.e_rd));
        chk($sformatf("v%0d_err", idx), 32'(err), 32'd0);
        if (e.chk_val) begin
            chk($sformatf("v%0d_valor", idx), 32'(valorGuardarRAM), 32'(e.e_val));
            chk($sformatf("v%0d_ovf", idx), 32'(ovf), 32'(e.e_ovf));
        end
        @(negedge clk);
        chk($sformatf("v%0d_state_after_show", idx), 32'(stateCPU), 32'd1);
        chk($sformatf("v%0d_disp_value", idx), 32'(disp_value), 32'(e.e_disp));
        chk($sformatf("v%0d_disp_valid", idx), 32'(disp_valid), 32'd1);
        if (e.exec_in_store) begin
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_store_exec_dropped", idx), 32'(stateCPU), 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        int n;
        //            instr    v1       v2       rd eis chk op    a1     a2     a3     val      ovf   disp     rdn
        vecs[0] = '{16'h0E7B, 16'h0000, 16'h0000, 1, 0, 1, 3'd0, 4'd7,  4'd0,  4'd0, 16'hFFFB, 1'b0, 16'hFFFB, 0};
        vecs[1] = '{16'h2624, 16'h0007, 16'h0009, 4, 0, 1, 3'd1, 4'd1,  4'd2,  4'd3, 16'h0010, 1'b0, 16'h0010, 5};
        vecs[2] = '{16'h8A21, 16'h8000, 16'h0000, 1, 0, 1, 3'd4, 4'd1,  4'd5,  4'd0, 16'h7FFF, 1'b1, 16'h7FFF, 2};
        vecs[3] = '{16'hAC44, 16'h4000, 16'h0000, 2, 0, 1, 3'd5, 4'd2,  4'd6,  4'd0, 16'h0000, 1'b1, 16'h0000, 3};
        vecs[4] = '{16'h4861, 16'h7FFF, 16'h0000, 1, 0, 1, 3'd2, 4'd3,  4'd4,  4'd0, 16'h8000, 1'b1, 16'h8000, 2};
        vecs[5] = '{16'hC000, 16'h0000, 16'h0000, 1, 1, 0, 3'd6, 4'd0,  4'd0,  4'd0, 16'h0000, 1'b0, 16'h0000, 0};
        vecs[6] = '{16'h7357, 16'h0005, 16'h0008, 3, 0, 1, 3'd3, 4'd10, 4'd11, 4'd9, 16'hFFFD, 1'b0, 16'hFFFD, 4};
        vecs[7] = '{16'hF9FF, 16'h1234, 16'h5555, 1, 0, 1, 3'd7, 4'd12, 4'd0,  4'd0, 16'h1234, 1'b0, 16'h1234, 2};
        vecs[8] = '{16'h41F0, 16'h0003, 16'h0000, 1, 0, 1, 3'd2, 4'd15, 4'd0,  4'd0, 16'hFFF3, 1'b0, 16'hFFF3, 2};
        vecs[9] = '{16'hA21D, 16'hFFFE, 16'h0000, 2, 0, 1, 3'd5, 4'd0,  4'd1,  4'd0, 16'h0006, 1'b0, 16'h0006, 3};

        rst = 1'b1; power = 1'b0; exec = 1'b0; instr = '0; v1RAM = '0; v2RAM = '0;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(stateCPU), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_addr1", 32'(addr1), 32'd0);
        chk("rst_addr2", 32'(addr2), 32'd0);
        chk("rst_addr3", 32'(addr3), 32'd0);
        chk("rst_valor", 32'(valorGuardarRAM), 32'd0);
        chk("rst_disp_value", 32'(disp_value), 32'd0);
        chk("rst_disp_valid", 32'(disp_valid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("off_without_power", 32'(stateCPU), 32'd0);
        power = 1'b1;
        @(negedge clk);
        chk("power_on_fetch", 32'(stateCPU), 32'd1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        power = 1'b0;
        @(negedge clk);
        chk("power_off_state", 32'(stateCPU), 32'd0);
        chk("power_off_disp_valid", 32'(disp_valid), 32'd0);
        power = 1'b1;
        @(negedge clk);
        chk("power_restore_fetch", 32'(stateCPU), 32'd1);

`ifdef HANDSHAKE_TIMEOUT_EN
        no_ack = 1'b1; instr = 16'h2624; v1RAM = 16'h0007; v2RAM = 16'h0009; exec = 1'b1;
        n = 0; done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            exec = 1'b0;
            if (stateCPU == 3'd3) n++;
            if (stateCPU == 3'd7) done = 1'b1;
        end
        chk("tmo_show_reached", 32'(done), 32'd1);
        chk("tmo_read_dwell", 32'(n), 32'd15);
        chk("tmo_err", 32'(err), 32'd1);
        @(negedge clk);
        chk("tmo_fetch", 32'(stateCPU), 32'd1);
        chk("tmo_disp_unchanged", 32'(disp_value), 32'h0006);
        no_ack = 1'b0;
        run_vec(vecs[1], 99);
`endif

        instr = 16'h2624; v1RAM = 16'h0007; v2RAM = 16'h0009; rd_delay = 1; exec = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            exec = 1'b0;
            if (stateCPU == 3'd4) done = 1'b1;
        end
        if (!done) begin
            total_cnt++;
            $display("FAIL calc_reached: got state %0d expected 4 within 50 cycles", stateCPU);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("calc_rst_state", 32'(stateCPU), 32'd0);
        chk("calc_rst_opcode", 32'(opcode), 32'd0);
        chk("calc_rst_addr3", 32'(addr3), 32'd0);
        chk("calc_rst_valor", 32'(valorGuardarRAM), 32'd0);
        chk("calc_rst_disp_value", 32'(disp_value), 32'd0);
        chk("calc_rst_disp_valid", 32'(disp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_fetch", 32'(stateCPU), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mini_cpu_control.md
Name: mini_cpu_control

Overview:
- Control unit that initiates every memory-bank transaction: walks OFF→FETCH→DECODE→READ→CALC→WAIT→STORE→SHOW.
- Decodes the 16-bit instruction into opcode/addr1/addr2/addr3 and computes the value to store.
- Waits on the memory's read/stored acknowledges and presents the result on display outputs.
- Sits between the board switches/buttons and the memory bank.

Parameters:
TIMEOUT_CYCLES, 15, max cycles spent in READ or STORE waiting for acknowledge (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
power  input  1  level; 1 = CPU on
exec  input  1  execute button, level; rising edge starts an instruction
instr  input  16  [15:13] opcode, remaining fields per opcode
v1RAM  input  16  operand 1 from memory
v2RAM  input  16  operand 2 from memory
read  input  1  memory read acknowledge
stored  input  1  memory store acknowledge
stateCPU  output  3  OFF=0 FETCH=1 DECODE=2 READ=3 CALC=4 WAIT=5 STORE=6 SHOW=7
opcode  output  3  LOAD=0 ADD=1 ADDI=2 SUB=3 SUBI=4 MUL=5 CLEAR=6 DISPLAY=7
addr1, addr2, addr3  output  4 each  memory addresses
valorGuardarRAM  output  16  value to store
disp_value  output  16  last result
disp_valid  output  1  high once any instruction completes; cleared on OFF
ovf  output  1  signed overflow of last arithmetic
err  output  1  handshake timeout (optional feature)

Behaviour:
- Reset: stateCPU=OFF; all other outputs 0. Reset mid-operation aborts immediately.
- Field decode, registered in DECODE:
  - LOAD: addr1=[12:9]; imm=sext([6:0]).
  - ADD/SUB: addr3=[12:9] (dest), addr1=[8:5], addr2=[4:1].
  - ADDI/SUBI/MUL: addr2=[12:9] (dest), addr1=[8:5], imm=sext([4:0]).
  - DISPLAY: addr1=[12:9].
  - CLEAR: no fields.
  - Unused address outputs are driven to 0.
- OFF: disp_valid=0. Minimum one cycle after reset. power=1 → FETCH.
- FETCH:
  - Rising edge of exec (registered previous sample) → latch instr, go to DECODE.
  - Else if power=0 → OFF.
  - exec edges in any other state are dropped, not queued.
- DECODE: one cycle. LOAD → CALC; CLEAR → WAIT; all others → READ.
- READ:
  - Hold until read=1.
  - On that cycle, latch v1RAM and v2RAM, then go to CALC.
  - The memory raises read one edge after it first samples READ, so the minimum READ dwell is 2 cycles.
- CALC: one cycle; register valorGuardarRAM, 16-bit two's-complement wrap:
  - LOAD = imm
  - ADD = v1+v2
  - ADDI = v1+imm
  - SUB = v1−v2
  - SUBI = v1−imm
  - MUL = low16(v1·imm), signed
  - DISPLAY = v1
  - ovf: set on signed overflow for ADD/ADDI/SUB/SUBI; for MUL when the 32-bit product ≠ sext(low16); 0 otherwise.
- WAIT: one cycle, operands stable → STORE.
- STORE: hold until stored=1 → SHOW.
- SHOW: one cycle. disp_value ← valorGuardarRAM (CLEAR: 0); disp_valid ← 1. Then → FETCH, where the memory drops stored.
- power=0 outside FETCH is ignored; it takes effect on return to FETCH.
- opcode/addr outputs hold from DECODE through SHOW, and until the next DECODE.

Optional Feature:
- Macro HANDSHAKE_TIMEOUT_EN.
- With it defined:
  - A counter resets on entry to READ or STORE.
  - If it reaches TIMEOUT_CYCLES without an acknowledge, set err=1 and jump to SHOW.
  - disp_value is not updated on a timeout.
  - err clears on the next DECODE.
- Without it: wait indefinitely; err tied to 0.

Decomposition:
- Package mini_cpu_pkg: state encodings, opcode encodings, instruction field bit positions.
- Sub-module mini_cpu_alu: combinational; inputs opcode, v1, v2, imm; outputs result and ovf. Instantiated once and registered in CALC.

Test Plan:
- LOAD instr=0x0E7B (dest 7, imm7=−5): → addr1=7; valorGuardarRAM=0xFFFB in STORE; READ skipped; disp_value=0xFFFB after SHOW.
- ADD dest 3, src 1, src 2 with v1=7, v2=9, read delayed 4 cycles: → stays in READ until read=1; addr3=3; stores 0x0010; ovf=0.
- SUBI v1=0x8000, imm=1: → 0x7FFF, ovf=1. MUL v1=0x4000, imm=4: → 0x0000, ovf=1.
- CLEAR: → DECODE→WAIT→STORE→SHOW; disp_value=0. exec pulse during STORE is ignored, leaving one instruction executed.
- rst asserted during CALC: → next cycle stateCPU=OFF, outputs 0. power=0 in FETCH → OFF.
- HANDSHAKE_TIMEOUT_EN, read never asserted: → after 15 cycles err=1, state SHOW, disp_value unchanged.
